pe_job_sequencer: RTL
=====================

# pe_job_sequencer

Sequences one PE through multi-chunk convolution jobs. Accepts a job command, buffers all of the job's 9-element in/weight chunks locally, then issues them to the PE on consecutive cycles so the PE's internal accumulation is never broken. Drives bias and bound level with the alignment the PE datapath requires, captures the final result on `pe_out_en`, and presents it on a valid/ready port. Sits between the tile feeder and one PE instance.

## Interface
- `CELL_BIT`, 8, bits per input/weight element
- `N_CELL`, 9, elements per chunk
- `BIAS_W`, 16, bias width
- `OUT_W`, 8, PE result width
- `MAX_CHUNK`, 8, buffer depth; a job has 1..8 chunks

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  job command valid
- `cmd_ready`  out  1  high in IDLE only
- `cmd_nchunk`  in  3  number of chunks minus 1
- `cmd_bias`  in  BIAS_W  signed bias, added once per job
- `cmd_bound`  in  2  bound level for the PE
- `dat_valid`  in  1  chunk valid
- `dat_ready`  out  1  high in LOAD only
- `dat_in`  in  CELL_BIT*N_CELL  chunk inputs
- `dat_weight`  in  CELL_BIT*N_CELL  chunk weights
- `pe_in`, `pe_weight`  out  CELL_BIT*N_CELL  to PE
- `pe_bias`  out  BIAS_W  to PE
- `pe_bound_level`  out  2  to PE
- `pe_step`  out  3  to PE
- `pe_en`  out  1  to PE
- `pe_out`  in  OUT_W  PE result
- `pe_out_en`  in  1  PE result strobe
- `res_valid`  out  1  result valid
- `res_ready`  in  1  result accepted
- `res_data`  out  OUT_W  signed job result
- `busy`  out  1  state != IDLE
- `err`  out  1  sticky protocol error

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch nchunk N, bias, and bound. Clear the load index, then go to LOAD.
- LOAD: `dat_ready`=1. Each `dat_valid` cycle writes buffer[idx] and increments idx. Gaps in `dat_valid` are allowed. After chunk N is written, go to ISSUE.
- ISSUE: runs N+1 consecutive cycles, k=0..N.
  - Drive `pe_en`=1, `pe_in`/`pe_weight`=buffer[k], and `pe_step`=N.
  - No gaps are allowed in this state.
  - Then go to WAIT.
- WAIT: drive `pe_en`=0. On `pe_out_en`=1, capture `pe_out` into `res_data`, set `res_valid`, and go to RESP.
- RESP: hold `res_data`. On `res_valid`&`res_ready`, clear `res_valid` and go to IDLE.
- `pe_bound_level` = latched bound from entry to ISSUE through exit from WAIT; 0 otherwise.
- `pe_bias` = latched bias only in the cycle after k=0 (the PE adds bias combinationally with its registered products); 0 in every other cycle. For N=0 this cycle is the first WAIT cycle.
- `pe_step`, `pe_in`, `pe_weight` = 0 outside ISSUE.
- Error conditions. Each sets `err`, which stays at 1 until reset:
  - `pe_out_en`=1 in any state other than WAIT.
  - `pe_out_en` not seen by the 2nd WAIT cycle. In this case the FSM still goes to RESP, with `res_data`=`pe_out`.
- Reset mid-operation (any state): return to IDLE next cycle and discard buffer contents. The PE shares the same reset.

## Timing
- Reset values:
  - `cmd_ready`=1, `dat_ready`=0, `pe_en`=0
  - `pe_in`=`pe_weight`=0, `pe_bias`=0, `pe_step`=0, `pe_bound_level`=0
  - `res_valid`=0, `res_data`=0, `busy`=0, `err`=0
- Command accepted at cycle C gives LOAD from C+1. Minimum LOAD length is N+1 cycles.
- ISSUE of chunk k occurs at cycle T+k.
- `pe_out_en` is expected at cycle T+N+2. `res_valid` rises at T+N+3.
- A new command can be accepted no earlier than the cycle after the result handshake.
- Job throughput is bounded by (N+1) load + (N+1) issue + 2 wait + 1 resp + 1 idle.

## Test plan
- N=0; all inputs 64, all weights 64; bias 0; bound 0. Required: `pe_en` for 1 cycle, `res_data`=36, `err`=0.
- N=3; all chunks inputs 32, weights 32; bias 1024; bound 0. Required: `pe_bias`=1024 only at T+1, `res_data`=37.
- N=0; inputs 64, weights 64; bound 3. Required: `res_data`=127 (saturated).
- LOAD with `dat_valid` toggling 1,0,0,1,1,0,1 for N=3. Required: ISSUE still runs 4 contiguous `pe_en` cycles with chunks in order.
- Hold `res_ready`=0 for 5 cycles. Required: `res_valid`/`res_data` stable, `cmd_ready`=0; `cmd_ready`=1 the cycle after the handshake.
- `reset`=0 during ISSUE k=2. Required: next cycle all outputs at reset values; a fresh N=0 job afterward gives the correct result.
- Force `pe_out_en` during LOAD. Required: `err`=1 and sticky until reset.

Source files
------------

// File: rtl/pe_job_sequencer_if.sv
// rtl/pe_job_sequencer_if.sv - job command, chunk, PE and result signals of pe_job_sequencer
interface pe_job_sequencer_if #(
    parameter int CELL_BIT = 8,
    parameter int N_CELL   = 9,
    parameter int BIAS_W   = 16,
    parameter int OUT_W    = 8
) ();
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [2:0]                   cmd_nchunk;
    logic [BIAS_W-1:0]            cmd_bias;
    logic [1:0]                   cmd_bound;
    logic                         dat_valid;
    logic                         dat_ready;
    logic [CELL_BIT*N_CELL-1:0]   dat_in;
    logic [CELL_BIT*N_CELL-1:0]   dat_weight;
    logic [CELL_BIT*N_CELL-1:0]   pe_in;
    logic [CELL_BIT*N_CELL-1:0]   pe_weight;
    logic [BIAS_W-1:0]            pe_bias;
    logic [1:0]                   pe_bound_level;
    logic [2:0]                   pe_step;
    logic                         pe_en;
    logic [OUT_W-1:0]             pe_out;
    logic                         pe_out_en;
    logic                         res_valid;
    logic                         res_ready;
    logic [OUT_W-1:0]             res_data;
    logic                         busy;
    logic                         err;

    modport master (
        output cmd_valid, cmd_nchunk, cmd_bias, cmd_bound,
        output dat_valid, dat_in, dat_weight,
        output pe_out, pe_out_en, res_ready,
        input  cmd_ready, dat_ready, pe_in, pe_weight, pe_bias, pe_bound_level,
        input  pe_step, pe_en, res_valid, res_data, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_nchunk, cmd_bias, cmd_bound,
        input  dat_valid, dat_in, dat_weight,
        input  pe_out, pe_out_en, res_ready,
        output cmd_ready, dat_ready, pe_in, pe_weight, pe_bias, pe_bound_level,
        output pe_step, pe_en, res_valid, res_data, busy, err
    );
endinterface

// File: rtl/pe_job_sequencer.sv
// rtl/pe_job_sequencer.sv - buffers a job's chunks and issues them back-to-back to one PE
module pe_job_sequencer #(
    parameter int CELL_BIT  = 8,
    parameter int N_CELL    = 9,
    parameter int BIAS_W    = 16,
    parameter int OUT_W     = 8,
    parameter int MAX_CHUNK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pe_job_sequencer_if.slave    bus
);
    localparam int CW = CELL_BIT * N_CELL;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        nchunk_q, nchunk_d;
    logic [BIAS_W-1:0] bias_q, bias_d;
    logic [1:0]        bound_q, bound_d;
    logic              wait_q, wait_d;
    logic [CW-1:0]     buf_in_q [MAX_CHUNK];
    logic [CW-1:0]     buf_in_d [MAX_CHUNK];
    logic [CW-1:0]     buf_w_q  [MAX_CHUNK];
    logic [CW-1:0]     buf_w_d  [MAX_CHUNK];

    logic              cmd_ready_q, cmd_ready_d;
    logic              dat_ready_q, dat_ready_d;
    logic              pe_en_q, pe_en_d;
    logic [CW-1:0]     pe_in_q, pe_in_d;
    logic [CW-1:0]     pe_weight_q, pe_weight_d;
    logic [BIAS_W-1:0] pe_bias_q, pe_bias_d;
    logic [1:0]        pe_bound_q, pe_bound_d;
    logic [2:0]        pe_step_q, pe_step_d;
    logic              res_valid_q, res_valid_d;
    logic [OUT_W-1:0]  res_data_q, res_data_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              wr_en;
    logic              bypass;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        nchunk_d    = nchunk_q;
        bias_d      = bias_q;
        bound_d     = bound_q;
        wait_d      = wait_q;
        buf_in_d    = buf_in_q;
        buf_w_d     = buf_w_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = err_q;
        wr_en       = (state_q == S_LOAD) && bus.dat_valid;

        if (wr_en) begin
            buf_in_d[idx_q] = bus.dat_in;
            buf_w_d[idx_q]  = bus.dat_weight;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    nchunk_d = bus.cmd_nchunk;
                    bias_d   = bus.cmd_bias;
                    bound_d  = bus.cmd_bound;
                    idx_d    = 3'd0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.dat_valid) begin
                    if (idx_q == nchunk_q) begin
                        idx_d   = 3'd0;
                        state_d = S_ISSUE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_ISSUE: begin
                if (idx_q == nchunk_q) begin
                    wait_d  = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_WAIT: begin
                // A late PE is flagged but the job still completes with whatever pe_out shows.
                if (bus.pe_out_en || wait_q) begin
                    res_data_d  = bus.pe_out;
                    res_valid_d = 1'b1;
                    state_d     = S_RESP;
                    if (!bus.pe_out_en) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.pe_out_en && state_q != S_WAIT) begin
            err_d = 1'b1;
        end

        // Outputs are registered, so they are derived from the next state; for N=0 the
        // only chunk is written and issued on adjacent cycles, hence the write bypass.
        bypass      = wr_en && (idx_q == idx_d);
        cmd_ready_d = (state_d == S_IDLE);
        dat_ready_d = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE);
        pe_en_d     = (state_d == S_ISSUE);
        pe_in_d     = '0;
        pe_weight_d = '0;
        pe_step_d   = 3'd0;
        if (pe_en_d) begin
            pe_in_d     = bypass ? bus.dat_in : buf_in_q[idx_d];
            pe_weight_d = bypass ? bus.dat_weight : buf_w_q[idx_d];
            pe_step_d   = nchunk_q;
        end
        // The PE adds bias alongside its registered first products, one cycle after k=0.
        pe_bias_d  = (state_q == S_ISSUE && idx_q == 3'd0) ? bias_q : '0;
        pe_bound_d = (state_d == S_ISSUE || state_d == S_WAIT) ? bound_q : 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            nchunk_q    <= 3'd0;
            bias_q      <= '0;
            bound_q     <= 2'd0;
            wait_q      <= 1'b0;
            for (int i = 0; i < MAX_CHUNK; i++) begin
                buf_in_q[i] <= '0;
                buf_w_q[i]  <= '0;
            end
            cmd_ready_q <= 1'b1;
            dat_ready_q <= 1'b0;
            pe_en_q     <= 1'b0;
            pe_in_q     <= '0;
            pe_weight_q <= '0;
            pe_bias_q   <= '0;
            pe_bound_q  <= 2'd0;
            pe_step_q   <= 3'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            nchunk_q    <= nchunk_d;
            bias_q      <= bias_d;
            bound_q     <= bound_d;
            wait_q      <= wait_d;
            buf_in_q    <= buf_in_d;
            buf_w_q     <= buf_w_d;
            cmd_ready_q <= cmd_ready_d;
            dat_ready_q <= dat_ready_d;
            pe_en_q     <= pe_en_d;
            pe_in_q     <= pe_in_d;
            pe_weight_q <= pe_weight_d;
            pe_bias_q   <= pe_bias_d;
            pe_bound_q  <= pe_bound_d;
            pe_step_q   <= pe_step_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.cmd_ready      = cmd_ready_q;
    assign bus.dat_ready      = dat_ready_q;
    assign bus.pe_en          = pe_en_q;
    assign bus.pe_in          = pe_in_q;
    assign bus.pe_weight      = pe_weight_q;
    assign bus.pe_bias        = pe_bias_q;
    assign bus.pe_bound_level = pe_bound_q;
    assign bus.pe_step        = pe_step_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_data       = res_data_q;
    assign bus.busy           = busy_q;
    assign bus.err            = err_q;
endmodule
